// File: rtl/phone_cmd_rx.sv
// Cell-phone command receiver: 8N1 UART decoder feeding a 4-byte packet parser
// (AA, cmd, data, cmd^data) that drives bounded motor/heart-rate settings.
module phone_cmd_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rxByte,
   output logic       rxByteValid,
   output logic [7:0] heartCap,
   output logic [7:0] assistLevel,
   output logic [1:0] modeSelect,
   output logic       cmdStrobe,
   output logic [7:0] frameErrCount,
   output logic [7:0] csumErrCount
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
   typedef enum logic [1:0] {P_WAIT_HDR, P_GET_CMD, P_GET_DATA, P_GET_CSUM} parse_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'd255) ? 8'd255 : v + 8'd1;
   endfunction

   function automatic logic [7:0] clamp_heart(input logic [7:0] v);
      if (v < 8'd60) begin
         return 8'd60;
      end else if (v > 8'd220) begin
         return 8'd220;
      end else begin
         return v;
      end
   endfunction

   function automatic logic [7:0] clamp_assist(input logic [7:0] v);
      return (v > 8'd100) ? 8'd100 : v;
   endfunction

   logic              sync1_q, sync2_q;
   uart_state_t       ustate_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shift_q;
   logic              armed_q;
   logic              frame_err_q;
   parse_state_t      pstate_q;
   logic [7:0]        cmd_q, data_q;
   logic [TMR_W-1:0]  timer_q;
   logic              rx_s;

   assign rx_s = sync2_q;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   // UART receive FSM with byte output and framing-error counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ustate_q      <= U_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'd0;
         armed_q       <= 1'b0;
         rxByte        <= 8'd0;
         rxByteValid   <= 1'b0;
         frame_err_q   <= 1'b0;
         frameErrCount <= 8'd0;
      end else begin
         rxByteValid <= 1'b0;
         frame_err_q <= 1'b0;
         case (ustate_q)
            U_IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= 3'd0;
               if (!rx_s && armed_q) begin
                  ustate_q <= U_START;
               end else if (rx_s) begin
                  armed_q <= 1'b1;
               end else begin
                  armed_q <= armed_q;
               end
            end
            U_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q    <= '0;
                  ustate_q <= rx_s ? U_IDLE : U_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            U_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_q <= 3'd0;
                     ustate_q  <= U_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            U_STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q    <= '0;
                  armed_q  <= 1'b0;
                  ustate_q <= U_IDLE;
                  if (rx_s) begin
                     rxByte      <= shift_q;
                     rxByteValid <= 1'b1;
                  end else begin
                     frame_err_q   <= 1'b1;
                     frameErrCount <= sat_inc(frameErrCount);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ustate_q <= U_IDLE;
         endcase
      end
   end

   // Packet parser, inter-byte timeout and command application.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pstate_q     <= P_WAIT_HDR;
         cmd_q        <= 8'd0;
         data_q       <= 8'd0;
         timer_q      <= '0;
         heartCap     <= 8'd200;
         assistLevel  <= 8'd0;
         modeSelect   <= 2'd0;
         cmdStrobe    <= 1'b0;
         csumErrCount <= 8'd0;
      end else begin
         cmdStrobe <= 1'b0;
         if (frame_err_q && (pstate_q != P_WAIT_HDR)) begin
            pstate_q <= P_WAIT_HDR;
            timer_q  <= '0;
         end else if (rxByteValid) begin
            timer_q <= '0;
            case (pstate_q)
               P_WAIT_HDR: begin
                  if (rxByte == 8'hAA) begin
                     pstate_q <= P_GET_CMD;
                  end else begin
                     pstate_q <= P_WAIT_HDR;
                  end
               end
               P_GET_CMD: begin
                  cmd_q    <= rxByte;
                  pstate_q <= P_GET_DATA;
               end
               P_GET_DATA: begin
                  data_q   <= rxByte;
                  pstate_q <= P_GET_CSUM;
               end
               P_GET_CSUM: begin
                  pstate_q <= P_WAIT_HDR;
                  if (rxByte == (cmd_q ^ data_q)) begin
                     case (cmd_q)
                        8'h01: begin
                           heartCap  <= clamp_heart(data_q);
                           cmdStrobe <= 1'b1;
                        end
                        8'h02: begin
                           assistLevel <= clamp_assist(data_q);
                           cmdStrobe   <= 1'b1;
                        end
                        8'h03: begin
                           modeSelect <= data_q[1:0];
                           cmdStrobe  <= 1'b1;
                        end
                        default: cmdStrobe <= 1'b0;
                     endcase
                  end else begin
                     csumErrCount <= sat_inc(csumErrCount);
                  end
               end
               default: pstate_q <= P_WAIT_HDR;
            endcase
         end else if (pstate_q != P_WAIT_HDR) begin
            if (timer_q == TMO_LAST) begin
               pstate_q <= P_WAIT_HDR;
               timer_q  <= '0;
            end else begin
               timer_q <= timer_q + TMR_W'(1);
            end
         end else begin
            timer_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_phone_cmd_rx.sv
// Directed bench for phone_cmd_rx: a packet-level model predicts bytes, commands and
// counters; a per-cycle monitor checks every byte/command pulse against it.
module tb_phone_cmd_rx;

   localparam int CPB = 10;
   localparam int TMO = 400;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rxByte, heartCap, assistLevel, frameErrCount, csumErrCount;
   logic       rxByteValid, cmdStrobe;
   logic [1:0] modeSelect;

   phone_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .rxByte(rxByte), .rxByteValid(rxByteValid),
      .heartCap(heartCap), .assistLevel(assistLevel), .modeSelect(modeSelect),
      .cmdStrobe(cmdStrobe), .frameErrCount(frameErrCount), .csumErrCount(csumErrCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int heart;
      int assist;
      int mode;
   } cmd_t;

   int tests = 0;
   int fails = 0;
   int exp_bytes[$];
   cmd_t exp_cmds[$];
   int m_state, m_cmd, m_data, m_heart, m_assist, m_mode, m_last;
   int m_frame, m_csum, m_nstrobe, seen_strobe;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cmd = 0; m_data = 0; m_last = 0;
      m_heart = 200; m_assist = 0; m_mode = 0;
      m_frame = 0; m_csum = 0; m_nstrobe = 0; seen_strobe = 0;
      exp_bytes.delete();
      exp_cmds.delete();
   endtask

   task automatic model_apply();
      cmd_t c;
      if (m_cmd == 1) begin
         m_heart = (m_data < 60) ? 60 : ((m_data > 220) ? 220 : m_data);
      end else if (m_cmd == 2) begin
         m_assist = (m_data > 100) ? 100 : m_data;
      end else if (m_cmd == 3) begin
         m_mode = m_data % 4;
      end else begin
         return;
      end
      c.heart = m_heart; c.assist = m_assist; c.mode = m_mode;
      exp_cmds.push_back(c);
      m_nstrobe++;
   endtask

   task automatic model_byte(input int b, input logic stop);
      if (!stop) begin
         if (m_frame < 255) m_frame++;
         m_state = 0;
         return;
      end
      exp_bytes.push_back(b);
      m_last = b;
      case (m_state)
         0: if (b == 'hAA) m_state = 1;
         1: begin m_cmd = b; m_state = 2; end
         2: begin m_data = b; m_state = 3; end
         default: begin
            m_state = 0;
            if (b == (m_cmd ^ m_data)) model_apply();
            else if (m_csum < 255) m_csum++;
         end
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      model_byte(int'(b), stop);
      @(negedge clk) rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
      send_byte(8'hAA, 1'b1);
      send_byte(c, 1'b1);
      send_byte(d, 1'b1);
      send_byte(s, 1'b1);
   endtask

   task automatic check_state(input string tag);
      check({tag, ":heartCap"}, int'(heartCap), m_heart);
      check({tag, ":assistLevel"}, int'(assistLevel), m_assist);
      check({tag, ":modeSelect"}, int'(modeSelect), m_mode);
      check({tag, ":frameErrCount"}, int'(frameErrCount), m_frame);
      check({tag, ":csumErrCount"}, int'(csumErrCount), m_csum);
      check({tag, ":rxByte"}, int'(rxByte), m_last);
      check({tag, ":strobes"}, seen_strobe, m_nstrobe);
      check({tag, ":missing_bytes"}, exp_bytes.size(), 0);
      check({tag, ":missing_cmds"}, exp_cmds.size(), 0);
      check({tag, ":assist_le_100"}, int'(assistLevel <= 8'd100), 1);
      check({tag, ":heart_in_range"}, int'(heartCap >= 8'd60 && heartCap <= 8'd220), 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ":rxByte"}, int'(rxByte), 0);
      check({tag, ":rxByteValid"}, int'(rxByteValid), 0);
      check({tag, ":cmdStrobe"}, int'(cmdStrobe), 0);
      check({tag, ":heartCap"}, int'(heartCap), 200);
      check({tag, ":assistLevel"}, int'(assistLevel), 0);
      check({tag, ":modeSelect"}, int'(modeSelect), 0);
      check({tag, ":frameErrCount"}, int'(frameErrCount), 0);
      check({tag, ":csumErrCount"}, int'(csumErrCount), 0);
   endtask

   // Per-cycle monitor: each byte or command pulse must match the model's next entry.
   always @(negedge clk) begin
      if (!reset) begin
         if (rxByteValid) begin
            if (exp_bytes.size() == 0) check("spurious_rxByteValid", 1, 0);
            else check("rxByte_pulse", int'(rxByte), exp_bytes.pop_front());
         end
         if (cmdStrobe) begin
            seen_strobe++;
            if (exp_cmds.size() == 0) begin
               check("spurious_cmdStrobe", 1, 0);
            end else begin
               cmd_t c;
               c = exp_cmds.pop_front();
               check("strobe_heartCap", int'(heartCap), c.heart);
               check("strobe_assistLevel", int'(assistLevel), c.assist);
               check("strobe_modeSelect", int'(modeSelect), c.mode);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_state("post_reset");

      send_pkt(8'h02, 8'h32, 8'h30);
      check_state("assist50");
      check("lit_assist50", int'(assistLevel), 50);
      check("lit_strobe_once", seen_strobe, 1);

      send_pkt(8'h01, 8'hF0, 8'hF1);
      check_state("heart_hi");
      check("lit_heart220", int'(heartCap), 220);
      send_pkt(8'h01, 8'h10, 8'h11);
      check_state("heart_lo");
      check("lit_heart60", int'(heartCap), 60);

      send_pkt(8'h03, 8'h02, 8'h00);
      check_state("bad_csum");
      check("lit_csum1", int'(csumErrCount), 1);
      check("lit_mode0", int'(modeSelect), 0);

      send_pkt(8'h03, 8'h02, 8'h01);
      check_state("mode2");
      check("lit_mode2", int'(modeSelect), 2);

      send_pkt(8'h05, 8'h11, 8'h14);
      check_state("unknown_cmd");

      send_byte(8'hAA, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h55, 1'b0);
      check_state("frame_err");
      check("lit_frame1", int'(frameErrCount), 1);
      send_pkt(8'h02, 8'h64, 8'h66);
      check_state("assist100");
      check("lit_assist100", int'(assistLevel), 100);

      send_byte(8'hAA, 1'b1);
      send_byte(8'h02, 1'b1);
      repeat (TMO + 100) @(negedge clk);
      m_state = 0;
      send_byte(8'h32, 1'b1);
      send_byte(8'h30, 1'b1);
      check_state("timeout");
      check("lit_assist_kept", int'(assistLevel), 100);

      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_state("glitch");

      for (int i = 0; i < 260; i++) send_byte(8'h00, 1'b0);
      check_state("frame_sat");
      check("lit_frame255", int'(frameErrCount), 255);

      send_byte(8'hAA, 1'b1);
      send_byte(8'h02, 1'b1);
      rx = 1'b0;
      repeat (3 * CPB + 5) @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      check_reset_values("mid_reset");
      reset = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      check_state("after_mid_reset");
      send_pkt(8'h02, 8'h32, 8'h30);
      check_state("restart");
      check("lit_restart_assist50", int'(assistLevel), 50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/phone_cmd_rx.md
PHONE_CMD_RX -- requirements
Module: phone_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter TIMEOUT_CLKS, default 50000, maximum idle clocks between bytes of one packet.
REQ-003 clk  input  1  system clock (50 MHz, c50m domain); all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  cell phone UART receive line; idles high; asynchronous to clk.
REQ-006 rxByte  output  8  last correctly framed byte.
REQ-007 rxByteValid  output  1  one-cycle pulse when rxByte updates.
REQ-008 heartCap  output  8  heart-rate cap in bpm.
REQ-009 assistLevel  output  8  motor assist percentage, 0..100.
REQ-010 modeSelect  output  2  motor mode select.
REQ-011 cmdStrobe  output  1  one-cycle pulse when a valid command is applied.
REQ-012 frameErrCount  output  8  count of framing errors; saturates at 255.
REQ-013 csumErrCount  output  8  count of checksum errors; saturates at 255.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all UART logic uses only the synchronized value.
REQ-015 UART RX SHALL have states IDLE, START, DATA, STOP and decode 8N1, LSB first.
REQ-016 IDLE->START on synchronized rx = 0, but only if rx was high for at least one clk since the last STOP.
REQ-017 START: at CLKS_PER_BIT/2 clks, rx = 0 -> DATA; rx = 1 -> IDLE (glitch: no byte, no error).
REQ-018 DATA: sample every CLKS_PER_BIT clks; after the 8th sample -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT clks.
  - rx = 1: rxByte is loaded and rxByteValid pulses on the next clk.
  - rx = 0: frameErrCount increments; no rxByteValid.
  - Either case: -> IDLE.
REQ-020 The parser SHALL have states WAIT_HDR, GET_CMD, GET_DATA, GET_CSUM and advance only on rxByteValid.
REQ-021 WAIT_HDR: byte 0xAA -> GET_CMD; any other byte is dropped.
REQ-022 GET_CMD latches cmd -> GET_DATA; GET_DATA latches data -> GET_CSUM.
REQ-023 GET_CSUM: expected = cmd XOR data (8-bit).
  - Match: apply the command, then -> WAIT_HDR.
  - Mismatch: csumErrCount increments, then -> WAIT_HDR.
REQ-024 Commands:
  - cmd 0x01: heartCap = data, clamped to 60..220.
  - cmd 0x02: assistLevel = min(data, 100).
  - cmd 0x03: modeSelect = data[1:0].
  - Any other cmd with a valid checksum: ignored; no strobe, no counter change.
REQ-025 On an applied command, the output register and cmdStrobe SHALL update in the same clk, one cycle after the csum byte's rxByteValid.
REQ-026 A framing error while the parser is not in WAIT_HDR SHALL force WAIT_HDR and discard the partial packet.
REQ-027 An inter-byte timer SHALL run while the parser is not in WAIT_HDR and reset on each rxByteValid; reaching TIMEOUT_CLKS forces WAIT_HDR, with no counter change.
REQ-028 If a framing error and a timeout occur in the same clk, the framing error is counted and the parser goes to WAIT_HDR once.
REQ-029 Both error counters SHALL hold at 255 (no wrap).
REQ-030 No input combination SHALL let assistLevel exceed 100 or heartCap leave 60..220.

Reset
REQ-031 While reset is high:
  - UART -> IDLE, parser -> WAIT_HDR, timer = 0, synchronizer flops = 1.
  - rxByte = 0, rxByteValid = 0, cmdStrobe = 0.
  - heartCap = 200, assistLevel = 0, modeSelect = 0.
  - frameErrCount = 0, csumErrCount = 0.
REQ-032 Reset asserted mid-byte or mid-packet SHALL discard all partial data; after release, the first valid start bit begins a new byte.

Verification
REQ-033 Send AA 02 32 30 at 115200 -> one rxByteValid per byte; cmdStrobe once; assistLevel = 50; csumErrCount = 0.
REQ-034 Send AA 01 F0 F1 -> heartCap = 220 (clamped). Send AA 01 10 11 -> heartCap = 60.
REQ-035 Send AA 03 02 00 (bad checksum) -> csumErrCount = 1; modeSelect stays 0; no cmdStrobe.
REQ-036 Send a byte with stop bit = 0 after AA 02 -> frameErrCount = 1. Then send AA 02 64 66 -> assistLevel = 100.
REQ-037 Send AA 02, idle 60000 clks, then 32 30 -> no command applied; assistLevel unchanged.
REQ-038 Drive a 100-clk low glitch on rx -> no rxByteValid, no counter change. Assert reset mid-packet -> all outputs return to REQ-031 values.
